// File: rtl/mem_stage_wide.sv
// mem_stage_wide: memory-access pipeline stage that holds the data memory.
//
// Performs scalar byte/halfword/word loads and stores, with sign or zero
// extension on sub-word loads. Also performs multi-beat wide loads of
// WIDE_WORDS consecutive words for the vector write path. Stall is high
// while a wide burst is in flight.
//
// Ports:
//   Clock        rising-edge clock
//   Reset        synchronous, active-high reset
//   MemRead      scalar load request
//   MemWrite     scalar store request
//   WideRead     wide load request
//   ByteSel      access size: 00 word, 01 byte, 10 halfword, 11 word
//   Unsigned     1 = zero-extend sub-word loads, 0 = sign-extend
//   Address      byte address; upper bits beyond the memory wrap
//   WriteData    store data, right-aligned
//   ReadData     scalar load result, holds between loads
//   ReadValid    one-cycle pulse when ReadData is updated
//   WideData     wide load result, word 0 in the LSBs
//   WideValid    one-cycle pulse when a burst has completed
//   Stall        high while a wide burst is in progress
//   MisalignErr  one-cycle pulse on a rejected misaligned request
module mem_stage_wide #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int WIDE_WORDS = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                             Clock,
    input  logic                             Reset,
    input  logic                             MemRead,
    input  logic                             MemWrite,
    input  logic                             WideRead,
    input  logic [1:0]                       ByteSel,
    input  logic                             Unsigned,
    input  logic [ADDR_WIDTH-1:0]            Address,
    input  logic [DATA_WIDTH-1:0]            WriteData,
    output logic [DATA_WIDTH-1:0]            ReadData,
    output logic                             ReadValid,
    output logic [DATA_WIDTH*WIDE_WORDS-1:0] WideData,
    output logic                             WideValid,
    output logic                             Stall,
    output logic                             MisalignErr
);

    localparam int IDX_W    = $clog2(DEPTH);
    localparam int BEAT_W   = (WIDE_WORDS > 1) ? $clog2(WIDE_WORDS) : 1;
    // Number of low byte-address bits that must be zero for a wide load.
    localparam int WALIGN_W = $clog2(WIDE_WORDS) + 2;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    // Extract the addressed field of a word and extend it to full width.
    function automatic logic [DATA_WIDTH-1:0] load_extract(
        input logic [DATA_WIDTH-1:0] word,
        input logic [1:0]            lane,
        input logic [1:0]            size,
        input logic                  zext
    );
        logic [7:0]            b;
        logic [15:0]           h;
        logic [DATA_WIDTH-1:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            2'b01:   r = zext ? {{(DATA_WIDTH-8){1'b0}}, b}
                          : {{(DATA_WIDTH-8){b[7]}}, b};
            2'b10:   r = zext ? {{(DATA_WIDTH-16){1'b0}}, h}
                          : {{(DATA_WIDTH-16){h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // True when a scalar access of the given size is not naturally aligned.
    function automatic logic scalar_misaligned(
        input logic [1:0] size,
        input logic [1:0] low
    );
        logic m;
        case (size)
            2'b01:   m = 1'b0;
            2'b10:   m = low[0];
            default: m = (low != 2'b00);
        endcase
        return m;
    endfunction

    logic [DATA_WIDTH-1:0]            mem_r [DEPTH];
    state_t                           state_r;
    state_t                           state_nx_s;
    logic [IDX_W-1:0]                 base_r;
    logic [BEAT_W-1:0]                beat_r;
    logic [DATA_WIDTH-1:0]            read_data_r;
    logic                             read_valid_r;
    logic [DATA_WIDTH*WIDE_WORDS-1:0] wide_data_r;
    logic                             wide_valid_r;
    logic                             misalign_r;

    logic [IDX_W-1:0]                 word_idx_s;
    logic [1:0]                       lane_s;
    logic                             scalar_mis_s;
    logic                             wide_mis_s;
    logic                             do_write_s;
    logic                             do_read_s;
    logic                             burst_start_s;
    logic                             misalign_s;
    logic                             last_beat_s;
    logic [IDX_W-1:0]                 burst_idx_s;
    logic [DATA_WIDTH-1:0]            wr_word_s;
    logic                             unused_addr_s;

    assign word_idx_s    = Address[IDX_W+1:2];
    assign lane_s        = Address[1:0];
    assign scalar_mis_s  = scalar_misaligned(ByteSel, lane_s);
    assign wide_mis_s    = (Address[WALIGN_W-1:0] != {WALIGN_W{1'b0}});
    assign last_beat_s   = (beat_r == BEAT_W'(WIDE_WORDS - 1));
    // Base is aligned to WIDE_WORDS, so base+beat never leaves the memory.
    assign burst_idx_s   = base_r + IDX_W'(beat_r);
    assign unused_addr_s = ^Address[ADDR_WIDTH-1:IDX_W+2];

    // Request decode: only in IDLE, write beats wide beats scalar read.
    always_comb begin
        do_write_s    = 1'b0;
        do_read_s     = 1'b0;
        burst_start_s = 1'b0;
        misalign_s    = 1'b0;
        if (!Reset && (state_r == ST_IDLE)) begin
            if (MemWrite) begin
                if (scalar_mis_s) begin
                    misalign_s = 1'b1;
                end else begin
                    do_write_s = 1'b1;
                end
            end else if (WideRead) begin
                if (wide_mis_s) begin
                    misalign_s = 1'b1;
                end else begin
                    burst_start_s = 1'b1;
                end
            end else if (MemRead) begin
                if (scalar_mis_s) begin
                    misalign_s = 1'b1;
                end else begin
                    do_read_s = 1'b1;
                end
            end else begin
                misalign_s = 1'b0;
            end
        end else begin
            misalign_s = 1'b0;
        end
    end

    // Store merge: replace only the addressed lane(s) of the current word.
    always_comb begin
        wr_word_s = mem_r[word_idx_s];
        case (ByteSel)
            2'b01:   wr_word_s[{lane_s, 3'b000} +: 8]     = WriteData[7:0];
            2'b10:   wr_word_s[{lane_s[1], 4'b0000} +: 16] = WriteData[15:0];
            default: wr_word_s = WriteData;
        endcase
    end

    // Wide-burst next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (burst_start_s) begin
                    state_nx_s = ST_BURST;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (last_beat_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_BURST;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Burst state register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Data memory: contents survive reset; writes land at the accepting edge.
    always_ff @(posedge Clock) begin
        if (do_write_s) begin
            mem_r[word_idx_s] <= wr_word_s;
        end
    end

    // Registered outputs, burst base and beat counter.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            base_r       <= {IDX_W{1'b0}};
            beat_r       <= {BEAT_W{1'b0}};
            read_data_r  <= {DATA_WIDTH{1'b0}};
            read_valid_r <= 1'b0;
            wide_data_r  <= {(DATA_WIDTH*WIDE_WORDS){1'b0}};
            wide_valid_r <= 1'b0;
            misalign_r   <= 1'b0;
        end else begin
            read_valid_r <= do_read_s;
            misalign_r   <= misalign_s;
            wide_valid_r <= 1'b0;
            if (do_read_s) begin
                read_data_r <= load_extract(mem_r[word_idx_s], lane_s, ByteSel, Unsigned);
            end
            if (burst_start_s) begin
                base_r <= word_idx_s;
                beat_r <= {BEAT_W{1'b0}};
            end
            if (state_r == ST_BURST) begin
                wide_data_r[beat_r*DATA_WIDTH +: DATA_WIDTH] <= mem_r[burst_idx_s];
                if (last_beat_s) begin
                    beat_r       <= {BEAT_W{1'b0}};
                    wide_valid_r <= 1'b1;
                end else begin
                    beat_r <= beat_r + BEAT_W'(1);
                end
            end
        end
    end

    assign ReadData    = read_data_r;
    assign ReadValid   = read_valid_r;
    assign WideData    = wide_data_r;
    assign WideValid   = wide_valid_r;
    assign MisalignErr = misalign_r;
    assign Stall       = (state_r == ST_BURST);

endmodule

// File: tb/tb_mem_stage_wide.sv
// tb_mem_stage_wide: directed, table-driven bench for mem_stage_wide with
// default parameters (32-bit words, 1024 words, 4-word wide loads).
// Single-cycle scalar operations come from a vector table; bursts, stalls
// and reset-mid-burst are exercised by hand-written sequences.
module tb_mem_stage_wide;

    logic         Clock = 1'b0;
    logic         Reset;
    logic         MemRead;
    logic         MemWrite;
    logic         WideRead;
    logic [1:0]   ByteSel;
    logic         Unsigned;
    logic [31:0]  Address;
    logic [31:0]  WriteData;
    logic [31:0]  ReadData;
    logic         ReadValid;
    logic [127:0] WideData;
    logic         WideValid;
    logic         Stall;
    logic         MisalignErr;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [127:0] WIDE_EXP = 128'h00000004_00000003_00000002_00000001;

    mem_stage_wide dut (
        .Clock(Clock), .Reset(Reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .WideRead(WideRead), .ByteSel(ByteSel), .Unsigned(Unsigned),
        .Address(Address), .WriteData(WriteData), .ReadData(ReadData),
        .ReadValid(ReadValid), .WideData(WideData), .WideValid(WideValid),
        .Stall(Stall), .MisalignErr(MisalignErr)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic        mr;
        logic        mw;
        logic        wr;
        logic [1:0]  bsel;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_rv;
        logic        exp_me;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic mr, input logic mw, input logic wr, input logic [1:0] bsel,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_rv, input logic exp_me);
        vec_t v;
        v = '{mr, mw, wr, bsel, uns, addr, wdata, exp_rd, exp_rv, exp_me};
        vq.push_back(v);
    endtask

    task automatic idle_inputs();
        MemRead = 1'b0; MemWrite = 1'b0; WideRead = 1'b0;
        ByteSel = 2'b00; Unsigned = 1'b0; Address = 32'h0; WriteData = 32'h0;
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Launch a wide load at addr (already idle) and check the whole burst.
    task automatic run_burst(input string tag, input logic [31:0] addr, input logic [127:0] exp);
        int cnt;
        int wv_cnt;
        WideRead = 1'b1; Address = addr;
        step();
        WideRead = 1'b0;
        cnt = 0; wv_cnt = 0;
        while (Stall && cnt < 20) begin
            cnt++;
            if (WideValid) wv_cnt++;
            step();
        end
        check({tag, "_stall_cycles"}, 128'(cnt), 128'd4);
        check({tag, "_no_early_valid"}, 128'(wv_cnt), 128'd0);
        check({tag, "_wide_valid"}, 128'(WideValid), 128'd1);
        check({tag, "_wide_data"}, WideData, exp);
        step();
        check({tag, "_wide_valid_pulse"}, 128'(WideValid), 128'd0);
        check({tag, "_wide_data_hold"}, WideData, exp);
    endtask

    initial begin
        int cnt;
        int wv_cnt;
        vec_t v;

        // mr mw wr bsel uns addr wdata exp_rd rv me
        add(0, 1, 0, 2'b00, 0, 32'h10,   32'hDEADBEEF, 32'h00000000, 0, 0);
        add(1, 0, 0, 2'b01, 0, 32'h13,   32'h0,        32'hFFFFFFDE, 1, 0);
        add(1, 0, 0, 2'b01, 1, 32'h13,   32'h0,        32'h000000DE, 1, 0);
        add(0, 1, 0, 2'b00, 0, 32'h20,   32'hAAAAAAAA, 32'h000000DE, 0, 0);
        add(0, 1, 0, 2'b10, 0, 32'h22,   32'h00001234, 32'h000000DE, 0, 0);
        add(1, 0, 0, 2'b00, 0, 32'h20,   32'h0,        32'h1234AAAA, 1, 0);
        add(1, 0, 0, 2'b10, 0, 32'h21,   32'h0,        32'h1234AAAA, 0, 1);
        add(1, 0, 0, 2'b00, 0, 32'h20,   32'h0,        32'h1234AAAA, 1, 0);
        add(1, 0, 0, 2'b10, 0, 32'h22,   32'h0,        32'h00001234, 1, 0);
        add(1, 0, 0, 2'b10, 0, 32'h20,   32'h0,        32'hFFFFAAAA, 1, 0);
        add(1, 0, 0, 2'b10, 1, 32'h20,   32'h0,        32'h0000AAAA, 1, 0);
        add(0, 1, 0, 2'b01, 0, 32'h11,   32'hFFFFFF5A, 32'h0000AAAA, 0, 0);
        add(1, 0, 0, 2'b00, 0, 32'h10,   32'h0,        32'hDEAD5AEF, 1, 0);
        add(0, 1, 0, 2'b00, 0, 32'h12,   32'h0,        32'hDEAD5AEF, 0, 1);
        add(1, 0, 0, 2'b11, 0, 32'h10,   32'h0,        32'hDEAD5AEF, 1, 0);
        add(1, 0, 0, 2'b01, 0, 32'h10,   32'h0,        32'hFFFFFFEF, 1, 0);
        add(1, 0, 0, 2'b01, 1, 32'h12,   32'h0,        32'h000000AD, 1, 0);
        add(0, 1, 0, 2'b00, 0, 32'h0,    32'hCAFEF00D, 32'h000000AD, 0, 0);
        add(1, 0, 0, 2'b00, 0, 32'h1000, 32'h0,        32'hCAFEF00D, 1, 0);
        add(1, 1, 0, 2'b00, 0, 32'h30,   32'h11112222, 32'hCAFEF00D, 0, 0);
        add(1, 0, 0, 2'b00, 0, 32'h30,   32'h0,        32'h11112222, 1, 0);
        add(0, 1, 0, 2'b00, 0, 32'h40,   32'h00000001, 32'h11112222, 0, 0);
        add(0, 1, 0, 2'b00, 0, 32'h44,   32'h00000002, 32'h11112222, 0, 0);
        add(0, 1, 0, 2'b00, 0, 32'h48,   32'h00000003, 32'h11112222, 0, 0);
        add(0, 1, 0, 2'b00, 0, 32'h4C,   32'h00000004, 32'h11112222, 0, 0);
        add(1, 0, 0, 2'b00, 0, 32'h4C,   32'h0,        32'h00000004, 1, 0);
        add(0, 1, 1, 2'b00, 0, 32'h50,   32'h00000055, 32'h00000004, 0, 0);
        add(1, 0, 0, 2'b00, 0, 32'h50,   32'h0,        32'h00000055, 1, 0);
        add(1, 0, 1, 2'b00, 0, 32'h44,   32'h0,        32'h00000055, 0, 1);

        // Reset state
        idle_inputs();
        Reset = 1'b1;
        step();
        step();
        check("rst_read_data", 128'(ReadData), 128'd0);
        check("rst_read_valid", 128'(ReadValid), 128'd0);
        check("rst_wide_data", WideData, 128'd0);
        check("rst_wide_valid", 128'(WideValid), 128'd0);
        check("rst_stall", 128'(Stall), 128'd0);
        check("rst_misalign", 128'(MisalignErr), 128'd0);
        Reset = 1'b0;
        step();

        // Table of single-cycle scalar operations
        foreach (vq[i]) begin
            v = vq[i];
            MemRead = v.mr; MemWrite = v.mw; WideRead = v.wr;
            ByteSel = v.bsel; Unsigned = v.uns; Address = v.addr; WriteData = v.wdata;
            step();
            check($sformatf("v%0d_read_valid", i), 128'(ReadValid), 128'(v.exp_rv));
            check($sformatf("v%0d_misalign", i), 128'(MisalignErr), 128'(v.exp_me));
            check($sformatf("v%0d_stall", i), 128'(Stall), 128'd0);
            check($sformatf("v%0d_read_data", i), 128'(ReadData), 128'(v.exp_rd));
        end
        idle_inputs();
        step();
        check("post_table_rv_low", 128'(ReadValid), 128'd0);

        // Aligned wide load
        run_burst("burst1", 32'h40, WIDE_EXP);

        // Misaligned wide load
        WideRead = 1'b1; Address = 32'h44;
        step();
        WideRead = 1'b0;
        check("wide_mis_err", 128'(MisalignErr), 128'd1);
        check("wide_mis_stall", 128'(Stall), 128'd0);
        check("wide_mis_no_wv", 128'(WideValid), 128'd0);
        step();
        check("wide_mis_err_pulse", 128'(MisalignErr), 128'd0);
        check("wide_mis_stall2", 128'(Stall), 128'd0);

        // Reset two beats into a burst
        WideRead = 1'b1; Address = 32'h40;
        step();
        WideRead = 1'b0;
        step();
        step();
        check("mid_rst_in_burst", 128'(Stall), 128'd1);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("mid_rst_stall", 128'(Stall), 128'd0);
        check("mid_rst_wide_valid", 128'(WideValid), 128'd0);
        check("mid_rst_wide_data", WideData, 128'd0);
        check("mid_rst_read_data", 128'(ReadData), 128'd0);
        check("mid_rst_read_valid", 128'(ReadValid), 128'd0);
        check("mid_rst_misalign", 128'(MisalignErr), 128'd0);
        wv_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (WideValid) wv_cnt++;
        end
        check("mid_rst_no_wv", 128'(wv_cnt), 128'd0);
        run_burst("burst2", 32'h40, WIDE_EXP);

        // Scalar load held while stalled
        WideRead = 1'b1; Address = 32'h40;
        step();
        WideRead = 1'b0;
        MemRead = 1'b1; Address = 32'h10; ByteSel = 2'b00;
        cnt = 0;
        while (Stall && cnt < 20) begin
            cnt++;
            check("hold_rd_no_rv", 128'(ReadValid), 128'd0);
            check("hold_rd_data", 128'(ReadData), 128'd0);
            step();
        end
        check("hold_rd_stall_cycles", 128'(cnt), 128'd4);
        check("hold_rd_rv_at_release", 128'(ReadValid), 128'd0);
        step();
        MemRead = 1'b0;
        check("hold_rd_accept_rv", 128'(ReadValid), 128'd1);
        check("hold_rd_accept_data", 128'(ReadData), 128'hDEAD5AEF);

        // Scalar store held while stalled
        WideRead = 1'b1; Address = 32'h40;
        step();
        WideRead = 1'b0;
        MemWrite = 1'b1; Address = 32'h40; ByteSel = 2'b00; WriteData = 32'h00000077;
        cnt = 0;
        while (Stall && cnt < 20) begin
            cnt++;
            check("hold_wr_rd_unchanged", 128'(ReadData), 128'hDEAD5AEF);
            step();
        end
        check("hold_wr_stall_cycles", 128'(cnt), 128'd4);
        check("hold_wr_wide_data", WideData, WIDE_EXP);
        step();
        MemWrite = 1'b0;
        MemRead = 1'b1; Address = 32'h40;
        step();
        MemRead = 1'b0;
        check("hold_wr_accept_rv", 128'(ReadValid), 128'd1);
        check("hold_wr_accept_data", 128'(ReadData), 128'h00000077);
        idle_inputs();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
